// File: rtl/ex_mem_wb_if.sv
// Data-memory request/response bus between the EX/MEM stage and the memory system.
// One request is outstanding at a time; mem_ready completes it on the active edge.
interface ex_mem_wb_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic [15:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ready, mem_rdata);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ready, mem_rdata);
endinterface

// File: rtl/ex_mem_wb.sv
// Back half of the pipeline: EX/MEM register, single-outstanding data-memory handshake,
// MEM/WB register driving the register-file write ports, and branch-flush generation.
module ex_mem_wb (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [3:0]  CAluop,
  input  logic [3:0]  op1pass,
  input  logic [1:0]  CregWrite,
  input  logic [1:0]  CmemWrite,
  input  logic        CmemToReg,
  input  logic        Cbranch,
  input  logic [15:0] alu_result,
  input  logic [15:0] alu_r0,
  input  logic        alu_zero,
  input  logic [15:0] store_data,
  input  logic [15:0] branchcorrectly,
  output logic [15:0] FutureAluresult,
  output logic [3:0]  Fwriteback,
  output logic        Fwb_en,
  output logic [15:0] Finresults,
  output logic        r0_we,
  output logic [15:0] r0_wdata,
  output logic        branched,
  output logic [15:0] branch_target,
  output logic        stall,
  ex_mem_wb_if.master mem
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} mstate_t;
  mstate_t state, state_nx;

  logic        m_valid, m_memtoreg;
  logic [1:0]  m_regwrite, m_memwrite;
  logic [3:0]  m_dst;
  logic [15:0] m_result, m_r0, m_wdata;

  logic ex_live, ex_mem, capture, take;
  logic m_store_op, m_mem_op, mem_done, wb_fire;
  logic unused;

  assign unused = ^CAluop;

  // The bundle seen while the flush pulse is up is the wrong-path instruction.
  assign ex_live = ex_valid & ~branched;
  assign ex_mem  = ex_live & ~Cbranch &
                   (CmemToReg | (CmemWrite == 2'b01) | (CmemWrite == 2'b10));
  assign capture = ~stall;
  assign take    = capture & ex_live & Cbranch & alu_zero;

  assign m_store_op = (m_memwrite == 2'b01) | (m_memwrite == 2'b10);
  assign m_mem_op   = m_valid & (m_store_op | m_memtoreg);
  assign mem_done   = ~m_mem_op | ((state == REQ) & mem.mem_ready);
  assign wb_fire    = m_valid & (|m_regwrite) & mem_done;

  // EX/MEM register; branches are captured as non-writing bubbles.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      m_valid    <= 1'b0;
      m_memtoreg <= 1'b0;
      m_regwrite <= 2'b00;
      m_memwrite <= 2'b00;
      m_dst      <= 4'h0;
      m_result   <= 16'h0;
      m_r0       <= 16'h0;
      m_wdata    <= 16'h0;
    end else if (capture) begin
      m_valid    <= ex_live & ~Cbranch;
      m_memtoreg <= CmemToReg;
      m_regwrite <= CregWrite;
      m_memwrite <= CmemWrite;
      m_dst      <= op1pass;
      m_result   <= alu_result;
      m_r0       <= alu_r0;
      m_wdata    <= (CmemWrite == 2'b10) ? {8'h00, store_data[7:0]} : store_data;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      branched      <= 1'b0;
      branch_target <= 16'h0;
    end else begin
      branched <= take;
      if (take) branch_target <= branchcorrectly;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // A new memory op captured on the completion edge keeps the request up.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ex_mem) state_nx = REQ;
      REQ:     if (mem.mem_ready) state_nx = ex_mem ? REQ : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem.mem_req = (state == REQ);
    mem.mem_we  = (state == REQ) & m_store_op;
  end

  assign mem.mem_addr    = m_result;
  assign mem.mem_wdata   = m_wdata;
  assign stall           = mem.mem_req & ~mem.mem_ready;
  assign FutureAluresult = m_result;

  // MEM/WB register; data fields only move when a writeback fires.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      Fwb_en     <= 1'b0;
      r0_we      <= 1'b0;
      Fwriteback <= 4'h0;
      Finresults <= 16'h0;
      r0_wdata   <= 16'h0;
    end else begin
      Fwb_en <= wb_fire;
      r0_we  <= wb_fire & (m_regwrite == 2'b10);
      if (wb_fire) begin
        Fwriteback <= m_dst;
        Finresults <= m_memtoreg ? mem.mem_rdata : m_result;
        r0_wdata   <= m_r0;
      end
    end
  end

endmodule
